// File: rtl/mdu_seq.sv
// mdu_seq: multicycle multiply/divide unit with internal HI/LO registers.
// Radix-2 shift-add multiplier and restoring divider, start/busy/done
// handshake, MTHI/MTLO write path.
// Optional: `define MDU_EARLY_OUT_EN lets MUL exit as soon as the remaining
// multiplier bits are zero (latency 3..WIDTH+2). In the default build every
// operation takes WIDTH+2 cycles.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);

  state_t             state;
  logic               prep;     // first MUL/DIV cycle loads magnitudes
  logic [CNT_W-1:0]   cnt;      // iterations completed
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r; // raw operands as presented at start
  logic [WIDTH-1:0]   mcand;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   mplier;   // remaining multiplier bits
  logic [2*WIDTH-1:0] acc;      // MUL: product accumulator; DIV: {rem,quo}

  logic               a_neg, b_neg, neg_q, neg_r;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_top;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes, sign fix-ups and one iteration step of each datapath
  always_comb begin
    a_neg    = ~op_r[0] & a_r[WIDTH-1];
    b_neg    = ~op_r[0] & b_r[WIDTH-1];
    neg_q    = a_neg ^ b_neg;
    neg_r    = a_neg;
    mag_a    = a_neg ? -a_r : a_r;
    mag_b    = b_neg ? -b_r : b_r;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    // shifted partial remainder needs one extra bit before the trial subtract
    div_top  = acc[2*WIDTH-1:WIDTH-1];
    div_ok   = div_top >= {1'b0, mcand};
    div_rem  = div_top[WIDTH-1:0] - mcand;
`ifdef MDU_EARLY_OUT_EN
    // skipped iterations were pure right shifts; apply them in one go
    prod     = acc >> (ITERS - cnt);
`else
    prod     = acc;
`endif
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prep     <= 1'b0;
      cnt      <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            cnt      <= '0;
            prep     <= 1'b1;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= op[1] ? DIV : MUL;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MUL: begin
          if (prep) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            prep   <= 1'b0;
          end
`ifdef MDU_EARLY_OUT_EN
          else if (mplier == '0) begin
            state <= FIX;
          end
`endif
          else begin
            acc    <= {mul_sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == ITERS - 1'b1) state <= FIX;
          end
        end
        DIV: begin
          if (prep) begin
            mcand <= mag_b;
            acc   <= {{WIDTH{1'b0}}, mag_a};
            prep  <= 1'b0;
          end else begin
            if (div_ok) acc <= {div_rem, acc[WIDTH-2:0], 1'b1};
            else        acc <= {acc[2*WIDTH-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (cnt == ITERS - 1'b1) state <= FIX;
          end
        end
        FIX: begin
          if (op_r[1]) begin
            if (b_r == '0) begin
              // divide by zero reports the untouched dividend
              hi       <= a_r;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised, multicycle multiply/divide unit for the multicycle CPU core.
- Successor to the combinational MDU:
  - iterative radix-2 shift-add multiplier and restoring divider;
  - internal HI/LO registers;
  - start/busy/done handshake;
  - MTHI/MTLO write path.
- Sits beside the ALU. The control FSM issues start and stalls on busy.
- HI/LO outputs feed MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH split HI:LO. Legal range 8..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- div_zero  out  1  sticky flag: last DIV/DIVU had b==0; cleared on next start
- hi  out  WIDTH  HI register (upper product / remainder)
- lo  out  WIDTH  LO register (lower product / quotient)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter and datapath registers cleared.
- FSM states:
  - IDLE -> MUL on start with op[1]=0; IDLE -> DIV on start with op[1]=1.
  - MUL/DIV -> FIX after WIDTH iterations.
  - FIX -> IDLE, asserting done in the same cycle hi/lo update.
- Capture at start: a, b, op latched.
  - Signed ops: magnitudes |a|, |b| computed as unsigned WIDTH-bit values (most-negative value maps to 2^(WIDTH-1)).
  - Store neg_q = a_sign^b_sign and neg_r = a_sign.
  - Unsigned ops: neg_q = neg_r = 0.
- MUL: each cycle, if multiplier LSB=1 add multiplicand into the upper half of a 2*WIDTH accumulator, then shift right by 1. WIDTH cycles.
- DIV (restoring): each cycle shift {rem,quo} left by 1, trial-subtract divisor from rem; if non-negative keep the result and set quo LSB. WIDTH cycles.
- FIX:
  - MUL: if neg_q, two's-complement negate the 2*WIDTH product.
  - DIV: if neg_q negate quotient; if neg_r negate remainder.
  - Write {hi,lo}.
- Latency: start sampled at edge N; busy=1 from N+1; done=1 and hi/lo valid at N+WIDTH+2. busy drops with done. A new start is accepted the cycle done is high (FSM is back in IDLE at that edge).
- Divide by zero (b==0): quotient=all ones, remainder=a (original signed/unsigned value, no sign fix); div_zero=1; same latency.
- Signed overflow (a=most-negative, b=-1): lo=most-negative, hi=0 (falls out of the magnitude algorithm); no flag.
- start while busy: ignored.
- hi_we/lo_we while busy: ignored (the operation result wins). In IDLE: hi<=wdata and/or lo<=wdata next edge; both strobes may be set together.
- start and hi_we/lo_we in the same IDLE cycle: start wins, the write is dropped.
- Reset mid-operation: abort; all state returns to reset values; no done pulse.
- op/a/b changes during busy: no effect (latched at start).

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - MUL leaves to FIX as soon as the remaining shifted multiplier bits are all zero; the accumulator is aligned by one extra multi-bit shift in FIX. Latency 3..WIDTH+2 cycles.
  - DIV is unchanged.
  - done/busy semantics are unchanged.
- Undefined: fixed WIDTH+2 latency for all ops. The bench must check exact cycle counts only in this configuration.

Test Plan:
- MULT a=0xFFFFFFFE(-2), b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done exactly 34 cycles after start (WIDTH=32, no early-out).
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7(0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_zero=1.
- IDLE: hi_we=1, wdata=0x1234 -> hi=0x1234. Then start MULTU 3*4 and pulse lo_we=1 mid-op -> lo_we ignored; final hi=0, lo=12. Second start while busy is ignored.
- Deassert rst_n at iteration 10 of a DIV -> hi=lo=0, busy=0, no done pulse. After release, MULT 5*6 completes normally with lo=30.
